// File: rtl/rv_ctrl_pkg.sv
// rv_ctrl_pkg: shared definitions for the RV32I multicycle controller.
//   - the seven opcode constants the controller accepts
//   - ALUOp encodings
//   - FSM state enum (3-bit) and the packed control-strobe bundle
//   - is_legal_op(): opcode membership test used in DECODE
package rv_ctrl_pkg;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [1:0] ALUOP_ADDR = 2'b00;  // LW/SW address add
  localparam logic [1:0] ALUOP_BR   = 2'b01;  // branch compare
  localparam logic [1:0] ALUOP_FUNC = 2'b10;  // R/I-type function field
  localparam logic [1:0] ALUOP_JUMP = 2'b11;  // JAL/JALR target

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic       alu_src;
    logic       mem_to_reg;
    logic [1:0] alu_op;
    logic       branch;
    logic       jal;
    logic       instr_done;
    logic       trap;
  } ctrl_t;

  function automatic logic is_legal_op(input logic [6:0] op);
    logic legal;
    legal = 1'b0;
    case (op)
      OP_IMM, OP_REG, OP_LOAD, OP_STORE,
      OP_BRANCH, OP_JAL, OP_JALR: legal = 1'b1;
      default:                    legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// mc_wait_timer: saturating wait-cycle counter for memory timeouts.
//   clk     in   clock
//   reset   in   asynchronous active-low reset (count -> 0)
//   clear   in   synchronous clear, wins over enable
//   enable  in   count one more wait cycle
//   limit   in   timeout threshold; 0 means never expire
//   expired out  count has reached limit (limit != 0)
// The count stops at all-ones so it can never wrap back below limit.
module mc_wait_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic             expired
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (limit != '0) && (count >= limit);

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM sequencing the RV32I datapath over
// FETCH -> DECODE -> EXEC -> [MEM] -> [WB] per instruction.
//
// Ports:
//   clk, reset      clock (rising edge); asynchronous active-low reset
//   Opcode[6:0]     instr[6:0] from IR, sampled into op_q in DECODE
//   mem_ready       memory completed the current request this cycle
//   mem_req, IorD, MemRead, MemWrite       memory port strobes
//   IRWrite, PCWrite, RegWrite, ALUSrc, MemtoReg, ALUOp[1:0], Branch,
//   jal_signal      datapath strobes
//   instr_done      one-cycle pulse on the cycle an instruction retires
//   trap            sticky error flag (illegal opcode or memory timeout)
//   state_dbg       current FSM state (FETCH while reset is asserted)
//
// Memory handshake: while mem_req=1 the request (IorD, MemRead, MemWrite)
// is held constant; the transfer completes in the cycle mem_ready=1 is
// sampled, and only then does the FSM leave FETCH/MEM. mem_ready has no
// meaning outside FETCH and MEM. If mem_ready stays low and the wait count
// has already reached TIMEOUT_CYCLES, the next edge goes to TRAP; mem_ready
// in that same cycle still completes normally.
//
// All outputs are forced to 0 combinationally while reset is low, so an
// abandoned instruction cannot leave a write strobe asserted.
// CNT_W must satisfy 2**CNT_W > TIMEOUT_CYCLES.
module multicycle_controller
  import rv_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] Opcode,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       ALUSrc,
  output logic       MemtoReg,
  output logic [1:0] ALUOp,
  output logic       Branch,
  output logic       jal_signal,
  output logic       instr_done,
  output logic       trap,
  output state_t     state_dbg
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

  state_t     state;
  state_t     state_next;
  logic [6:0] op_q;
  logic       waiting;
  logic       timer_clear;
  logic       expired;
  ctrl_t      ctrl;

  // State and opcode registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
      op_q  <= '0;
    end else begin
      state <= state_next;
      if (state == DECODE) begin
        op_q <= Opcode;
      end
    end
  end

  // Wait counter: counts cycles spent in FETCH/MEM with mem_ready low.
  // Any state change (including entry to FETCH/MEM) or a completed
  // transfer restarts it from zero.
  assign waiting     = ((state == FETCH) || (state == MEM)) && !mem_ready;
  assign timer_clear = (state_next != state) || mem_ready;

  mc_wait_timer #(
    .CNT_W (CNT_W)
  ) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (timer_clear),
    .enable  (waiting),
    .limit   (LIMIT),
    .expired (expired)
  );

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      FETCH: begin
        if (mem_ready) begin
          state_next = DECODE;
        end else if (expired) begin
          state_next = TRAP;
        end
      end
      DECODE: begin
        state_next = is_legal_op(Opcode) ? EXEC : TRAP;
      end
      EXEC: begin
        case (op_q)
          OP_BRANCH:                       state_next = FETCH;
          OP_LOAD, OP_STORE:               state_next = MEM;
          OP_REG, OP_IMM, OP_JAL, OP_JALR: state_next = WB;
          default:                         state_next = TRAP;
        endcase
      end
      MEM: begin
        if (mem_ready) begin
          state_next = (op_q == OP_LOAD) ? WB : FETCH;
        end else if (expired) begin
          state_next = TRAP;
        end
      end
      WB:      state_next = FETCH;
      TRAP:    state_next = TRAP;
      default: state_next = TRAP;
    endcase
  end

  // Output decode from state and op_q (IRWrite/PCWrite and the SW retire
  // pulse additionally look at mem_ready).
  always_comb begin
    ctrl = '0;
    if (reset) begin
      case (state)
        FETCH: begin
          ctrl.mem_req  = 1'b1;
          ctrl.mem_read = 1'b1;
          ctrl.ir_write = mem_ready;
          ctrl.pc_write = mem_ready;
        end
        DECODE: begin
        end
        EXEC: begin
          case (op_q)
            OP_REG: begin
              ctrl.alu_op = ALUOP_FUNC;
            end
            OP_IMM: begin
              ctrl.alu_src = 1'b1;
              ctrl.alu_op  = ALUOP_FUNC;
            end
            OP_LOAD, OP_STORE: begin
              ctrl.alu_src = 1'b1;
              ctrl.alu_op  = ALUOP_ADDR;
            end
            OP_BRANCH: begin
              ctrl.alu_op     = ALUOP_BR;
              ctrl.branch     = 1'b1;
              ctrl.instr_done = 1'b1;
            end
            OP_JAL, OP_JALR: begin
              ctrl.alu_src = 1'b1;
              ctrl.alu_op  = ALUOP_JUMP;
              ctrl.branch  = 1'b1;
            end
            default: begin
            end
          endcase
        end
        MEM: begin
          ctrl.mem_req    = 1'b1;
          ctrl.iord       = 1'b1;
          ctrl.mem_read   = (op_q == OP_LOAD);
          ctrl.mem_write  = (op_q == OP_STORE);
          ctrl.instr_done = mem_ready && (op_q == OP_STORE);
        end
        WB: begin
          ctrl.reg_write  = 1'b1;
          ctrl.mem_to_reg = (op_q == OP_LOAD);
          ctrl.jal        = (op_q == OP_JAL) || (op_q == OP_JALR);
          ctrl.instr_done = 1'b1;
        end
        TRAP: begin
          ctrl.trap = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign mem_req    = ctrl.mem_req;
  assign IorD       = ctrl.iord;
  assign MemRead    = ctrl.mem_read;
  assign MemWrite   = ctrl.mem_write;
  assign IRWrite    = ctrl.ir_write;
  assign PCWrite    = ctrl.pc_write;
  assign RegWrite   = ctrl.reg_write;
  assign ALUSrc     = ctrl.alu_src;
  assign MemtoReg   = ctrl.mem_to_reg;
  assign ALUOp      = ctrl.alu_op;
  assign Branch     = ctrl.branch;
  assign jal_signal = ctrl.jal;
  assign instr_done = ctrl.instr_done;
  assign trap       = ctrl.trap;
  assign state_dbg  = reset ? state : FETCH;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: the driver walks each instruction phase
// by phase and pushes the output vector every cycle should show; a monitor
// on the falling edge pops and compares.
module tb_multicycle_controller;
  import rv_ctrl_pkg::*;

  localparam int W    = 15;
  localparam int TOUT = 4;

  // Expected-vector bit masks
  localparam logic [W-1:0] M_REQ   = 15'h0001;
  localparam logic [W-1:0] M_IORD  = 15'h0002;
  localparam logic [W-1:0] M_MRD   = 15'h0004;
  localparam logic [W-1:0] M_MWR   = 15'h0008;
  localparam logic [W-1:0] M_IRW   = 15'h0010;
  localparam logic [W-1:0] M_PCW   = 15'h0020;
  localparam logic [W-1:0] M_REGW  = 15'h0040;
  localparam logic [W-1:0] M_ASRC  = 15'h0080;
  localparam logic [W-1:0] M_MTR   = 15'h0100;
  localparam logic [W-1:0] M_A_BR  = 15'h0200;
  localparam logic [W-1:0] M_A_FN  = 15'h0400;
  localparam logic [W-1:0] M_A_JMP = 15'h0600;
  localparam logic [W-1:0] M_BRN   = 15'h0800;
  localparam logic [W-1:0] M_JAL   = 15'h1000;
  localparam logic [W-1:0] M_DONE  = 15'h2000;
  localparam logic [W-1:0] M_TRAP  = 15'h4000;

  localparam logic [6:0] T_I    = 7'b0010011;
  localparam logic [6:0] T_R    = 7'b0110011;
  localparam logic [6:0] T_LW   = 7'b0000011;
  localparam logic [6:0] T_SW   = 7'b0100011;
  localparam logic [6:0] T_BR   = 7'b1100011;
  localparam logic [6:0] T_JAL  = 7'b1101111;
  localparam logic [6:0] T_JALR = 7'b1100111;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] Opcode;
  logic       mem_ready;
  logic       mem_req, IorD, MemRead, MemWrite, IRWrite, PCWrite, RegWrite;
  logic       ALUSrc, MemtoReg, Branch, jal_signal, instr_done, trap;
  logic [1:0] ALUOp;
  state_t     state_dbg;
  logic [W-1:0] act_vec;

  always #5 clk = ~clk;

  multicycle_controller #(
    .TIMEOUT_CYCLES (TOUT),
    .CNT_W          (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .Opcode     (Opcode),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .IorD       (IorD),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .PCWrite    (PCWrite),
    .RegWrite   (RegWrite),
    .ALUSrc     (ALUSrc),
    .MemtoReg   (MemtoReg),
    .ALUOp      (ALUOp),
    .Branch     (Branch),
    .jal_signal (jal_signal),
    .instr_done (instr_done),
    .trap       (trap),
    .state_dbg  (state_dbg)
  );

  assign act_vec = {trap, instr_done, jal_signal, Branch, ALUOp, MemtoReg, ALUSrc,
                    RegWrite, PCWrite, IRWrite, MemWrite, MemRead, IorD, mem_req};

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_v;
  int checks = 0;
  int errors = 0;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      checks++;
      if (act_vec !== exp_v) begin
        errors++;
        $display("FAIL cycle_trace t=%0t state=%0d: outputs=%h required=%h",
                 $time, state_dbg, act_vec, exp_v);
      end
    end
  end

  // ---------------- reference model helpers ----------------
  function automatic logic is_legal(input logic [6:0] op);
    return (op == T_I) || (op == T_R) || (op == T_LW) || (op == T_SW) ||
           (op == T_BR) || (op == T_JAL) || (op == T_JALR);
  endfunction

  function automatic logic [W-1:0] exec_vec(input logic [6:0] op);
    logic [W-1:0] v;
    v = '0;
    if (op == T_R)                     v = M_A_FN;
    if (op == T_I)                     v = M_A_FN | M_ASRC;
    if (op == T_LW || op == T_SW)      v = M_ASRC;
    if (op == T_BR)                    v = M_A_BR | M_BRN | M_DONE;
    if (op == T_JAL || op == T_JALR)   v = M_A_JMP | M_BRN | M_ASRC;
    return v;
  endfunction

  function automatic logic [6:0] rnd_op();
    return 7'($urandom_range(0, 127));
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [6:0] pick_op();
    int p;
    p = $urandom_range(0, 15);
    case (p)
      0, 7:   return T_I;
      1, 8:   return T_R;
      2, 9:   return T_LW;
      3, 10:  return T_SW;
      4, 11:  return T_BR;
      5, 12:  return T_JAL;
      6, 13:  return T_JALR;
      14:     return 7'b0110111;
      default: return 7'b1111111;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  // Called at posedge+1: apply inputs for this cycle, record expectation.
  task automatic drive_cycle(input logic rdy, input logic [6:0] op, input logic [W-1:0] e);
    mem_ready = rdy;
    Opcode    = op;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    #1;
    checks++;
    if (act_vec !== '0) begin
      errors++;
      $display("FAIL reset_async: outputs=%h required=%h", act_vec, {W{1'b0}});
    end
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('0);
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
  endtask

  task automatic trap_tail(input int n);
    for (int i = 0; i < n; i++) drive_cycle(rnd_bit(), rnd_op(), M_TRAP);
  endtask

  // One instruction. fw/mw = cycles of mem_ready low before the transfer
  // completes; more than TOUT means the transfer never completes.
  // mem_abort >= 0: reset is pulsed after that many MEM wait cycles.
  task automatic run_instr(input logic [6:0] op, input int fw, input int mw,
                           input int mem_abort, output bit need_reset);
    logic [W-1:0] mv;
    need_reset = 1'b0;
    for (int i = 0; i < fw && i <= TOUT; i++) drive_cycle(1'b0, rnd_op(), M_REQ | M_MRD);
    if (fw > TOUT) begin
      trap_tail(3);
      need_reset = 1'b1;
      return;
    end
    drive_cycle(1'b1, rnd_op(), M_REQ | M_MRD | M_IRW | M_PCW);
    drive_cycle(rnd_bit(), op, '0);
    if (!is_legal(op)) begin
      trap_tail(22);
      need_reset = 1'b1;
      return;
    end
    drive_cycle(rnd_bit(), rnd_op(), exec_vec(op));
    if (op == T_BR) return;
    if (op == T_LW || op == T_SW) begin
      mv = M_REQ | M_IORD | ((op == T_LW) ? M_MRD : M_MWR);
      if (mem_abort >= 0) begin
        for (int i = 0; i < mem_abort; i++) drive_cycle(1'b0, rnd_op(), mv);
        do_reset(2);
        return;
      end
      for (int i = 0; i < mw && i <= TOUT; i++) drive_cycle(1'b0, rnd_op(), mv);
      if (mw > TOUT) begin
        trap_tail(3);
        need_reset = 1'b1;
        return;
      end
      drive_cycle(1'b1, rnd_op(), mv | ((op == T_SW) ? M_DONE : '0));
      if (op == T_SW) return;
    end
    drive_cycle(rnd_bit(), rnd_op(),
                M_REGW | M_DONE | ((op == T_LW) ? M_MTR : '0) |
                ((op == T_JAL || op == T_JALR) ? M_JAL : '0));
  endtask

  task automatic run_and_recover(input logic [6:0] op, input int fw, input int mw,
                                 input int mem_abort);
    bit nr;
    run_instr(op, fw, mw, mem_abort, nr);
    if (nr) do_reset($urandom_range(1, 3));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset     = 1'b0;
    mem_ready = 1'b0;
    Opcode    = '0;
    #1;
    checks++;
    if (act_vec !== '0) begin
      errors++;
      $display("FAIL reset_init: outputs=%h required=%h", act_vec, {W{1'b0}});
    end
    @(posedge clk);
    #1;
    do_reset(2);

    // Directed cases
    run_and_recover(T_R,    0, 0, -1);
    run_and_recover(T_LW,   0, 3, -1);
    run_and_recover(T_SW,   0, 0, -1);
    run_and_recover(T_BR,   0, 0, -1);
    run_and_recover(T_JAL,  0, 0, -1);
    run_and_recover(T_I,    1, 0, -1);
    run_and_recover(T_JALR, 2, 0, -1);
    run_and_recover(T_LW,   TOUT, TOUT, -1);      // ready exactly at the limit
    run_and_recover(T_SW,   0, 0, 1);             // reset during MEM
    run_and_recover(T_SW,   0, 1, -1);
    run_and_recover(7'b1111111, 0, 0, -1);        // illegal opcode
    run_and_recover(T_R,    TOUT + 1, 0, -1);     // FETCH timeout
    run_and_recover(T_LW,   0, TOUT + 1, -1);     // MEM timeout
    run_and_recover(T_BR,   0, 0, -1);

    // Randomized stream
    for (int n = 0; n < 60; n++) begin
      logic [6:0] op;
      int fw, mw, ab;
      op = pick_op();
      fw = ($urandom_range(0, 19) == 0) ? TOUT + 1 : $urandom_range(0, TOUT);
      mw = ($urandom_range(0, 9) == 0) ? TOUT + 1 : $urandom_range(0, TOUT);
      ab = ($urandom_range(0, 11) == 0) ? $urandom_range(0, 2) : -1;
      run_and_recover(op, fw, mw, ab);
    end

    @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: left=%0d required=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: time=%0t limit=1000000", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
